// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared types, constants and the round-robin search helper for the ALU
// arbiter slice (alu_arbiter, rr_arbiter).
//   state_e        : arbiter FSM state encoding (IDLE, EXEC, RESP)
//   DATA_W_DEF     : default operand/result width of the shared ALU
//   SEL_W          : width of the ALU function select
//   RR_MAX_REQ     : largest requester count the search helper supports
//   rr_next_index  : first requesting index searching upward from ptr+1
// -----------------------------------------------------------------------------
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 16;
  localparam int SEL_W      = 4;
  localparam int RR_MAX_REQ = 8;

  // Returns the first index with its req bit set, visiting ptr+1, ptr+2, ...
  // modulo num_req. ptr < num_req and the offset never exceeds num_req, so a
  // single conditional subtraction replaces a modulo. Only meaningful when at
  // least one req bit below num_req is set; returns 0 otherwise.
  function automatic logic [2:0] rr_next_index(input logic [7:0] req,
                                               input logic [2:0] ptr,
                                               input int         num_req);
    logic [2:0] pick;
    logic       found;
    logic [3:0] idx;
    pick  = 3'd0;
    found = 1'b0;
    for (int i = 1; i <= RR_MAX_REQ; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= 4'(num_req)) begin
        idx = idx - 4'(num_req);
      end else begin
        idx = idx;
      end
      if ((i <= num_req) && !found && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end else begin
        pick  = pick;
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The pointer names the previous
// winner; the search starts one position above it and wraps.
//   req_i      [NUM_REQ-1:0] : request vector
//   rr_ptr_i   [ID_W-1:0]    : previous winner index
//   gnt_o      [NUM_REQ-1:0] : one-hot winner, all zero when req_i == 0
//   gnt_idx_o  [ID_W-1:0]    : winner index (don't care when req_i == 0)
// -----------------------------------------------------------------------------
module rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o
);

  logic [7:0] req_pad_s;
  logic [2:0] pick_s;

  // Winner search and one-hot decode.
  always_comb begin
    req_pad_s = 8'(req_i);
    pick_s    = rr_next_index(req_pad_s, 3'(rr_ptr_i), NUM_REQ);
    gnt_idx_o = ID_W'(pick_s);
    if (|req_i) begin
      gnt_o = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_o;
    end else begin
      gnt_o = '0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU among NUM_REQ requesters. A winner is
// picked round-robin in IDLE, its operands are registered onto the ALU inputs,
// the ALU output is captured one cycle later and returned with the winner's
// index over a valid/ready channel.
//
// Optional feature macro: ALU_ARB_OP_COUNT_EN
//   When defined, adds op_count[15:0], a wrapping count of completed responses.
//
// Ports:
//   clk, rst              : clock (rising edge), synchronous active-high reset
//   req                   : per-requester request, held until granted
//   req_a, req_b          : packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_select, req_mode  : packed ALU select (4 bits each) and mode per requester
//   gnt                   : one-hot grant pulse, operands sampled that cycle
//   alu_a, alu_b          : registered ALU operands
//   alu_select, alu_mode  : registered ALU function
//   alu_result            : combinational ALU output
//   rsp_valid, rsp_data,
//   rsp_id, rsp_ready     : response channel (result + requester index)
//   busy                  : high whenever the FSM is not in IDLE
//   op_count              : (ALU_ARB_OP_COUNT_EN only) completed-response count
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*SEL_W-1:0]  req_select,
  input  logic [NUM_REQ-1:0]        req_mode,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [SEL_W-1:0]          alu_select,
  output logic                      alu_mode,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  input  logic                      rsp_ready,
  output logic                      busy
`ifdef ALU_ARB_OP_COUNT_EN
  ,
  output logic [15:0]               op_count
`endif
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [SEL_W-1:0]    alu_select_q, alu_select_d;
  logic                alu_mode_q, alu_mode_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [NUM_REQ-1:0]  arb_gnt_s;
  logic [ID_W-1:0]     arb_idx_s;
  logic [NUM_REQ-1:0]  gnt_s;
  logic                rsp_done_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i     (req),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (arb_gnt_s),
    .gnt_idx_o (arb_idx_s)
  );

  assign rsp_done_s = rsp_valid_q & rsp_ready;

  // Next-state, register next values and grant decode.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_select_d = alu_select_q;
    alu_mode_d   = alu_mode_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    gnt_s        = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_s        = arb_gnt_s;
          alu_a_d      = req_a[arb_idx_s*DATA_W +: DATA_W];
          alu_b_d      = req_b[arb_idx_s*DATA_W +: DATA_W];
          alu_select_d = req_select[arb_idx_s*SEL_W +: SEL_W];
          alu_mode_d   = req_mode[arb_idx_s];
          rr_ptr_d     = arb_idx_s;
          rsp_id_d     = arb_idx_s;
          state_d      = EXEC;
        end else begin
          state_d      = IDLE;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_result;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_done_s) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d     = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The grant is a same-cycle pulse; suppress it while reset is asserted so
  // no requester believes it was served in the reset cycle.
  always_comb begin
    if (rst) begin
      gnt = '0;
    end else begin
      gnt = gnt_s;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= ID_W'(NUM_REQ - 1);
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_select_q <= '0;
      alu_mode_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_select_q <= alu_select_d;
      alu_mode_q   <= alu_mode_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = alu_select_q;
  assign alu_mode   = alu_mode_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = (state_q != IDLE);

`ifdef ALU_ARB_OP_COUNT_EN
  logic [15:0] op_count_q;

  // Completed-response counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= 16'd0;
    end else if (rsp_done_s) begin
      op_count_q <= op_count_q + 16'd1;
    end else begin
      op_count_q <= op_count_q;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed plus randomized bench for alu_arbiter. Provides a behavioural ALU
// on the alu_* side and predicts grants and responses from a round-robin
// model that remembers the last winner.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N*4-1:0]  req_select;
  logic [N-1:0]    req_mode;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [3:0]      alu_select;
  logic            alu_mode;
  logic [DW-1:0]   alu_result;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      rsp_id;
  logic            rsp_ready;
  logic            busy;
`ifdef ALU_ARB_OP_COUNT_EN
  logic [15:0]     op_count;
`endif

  int vectors;
  int miscompares;
  int last;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_select (req_select),
    .req_mode   (req_mode),
    .gnt        (gnt),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_mode   (alu_mode),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
`ifdef ALU_ARB_OP_COUNT_EN
    ,
    .op_count   (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU standing in for the shared unit.
  function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] s, input logic m);
    if (m) begin
      case (s)
        4'h0:    return ~a;
        4'h6:    return a ^ b;
        4'hB:    return a & b;
        4'hE:    return a | b;
        4'hF:    return a;
        default: return a & ~b;
      endcase
    end else begin
      case (s)
        4'h9:    return a + b;
        4'h6:    return a - b;
        4'h0:    return a;
        4'hC:    return a + a;
        default: return a + b + {12'd0, s};
      endcase
    end
  endfunction

  always_comb alu_result = alu_fn(alu_a, alu_b, alu_select, alu_mode);

  // Round-robin rule: first requesting index after the last winner, wrapping.
  function automatic int pick(input logic [3:0] r);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] s, input logic m);
    req_a[i*DW +: DW]    = a;
    req_b[i*DW +: DW]    = b;
    req_select[i*4 +: 4] = s;
    req_mode[i]          = m;
  endtask

  // One full operation starting in an IDLE cycle (called at posedge+1).
  task automatic txn(input string tag, input logic [3:0] reqv, input bit drop,
                     input int delay, input bit chk_zero);
    int w;
    logic [15:0] ea, eb, ed;
    logic [3:0]  es;
    logic        em;
    req = reqv;
    w   = pick(reqv);
    ea  = req_a[w*DW +: DW];
    eb  = req_b[w*DW +: DW];
    es  = req_select[w*4 +: 4];
    em  = req_mode[w];
    ed  = alu_fn(ea, eb, es, em);
    @(negedge clk);
    check({tag, "_gnt"}, 32'(gnt), 32'(1) << w);
    check({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
    if (chk_zero) begin
      check({tag, "_rst_alu_a"}, 32'(alu_a), 32'd0);
      check({tag, "_rst_alu_b"}, 32'(alu_b), 32'd0);
      check({tag, "_rst_sel"}, 32'(alu_select), 32'd0);
      check({tag, "_rst_mode"}, 32'(alu_mode), 32'd0);
      check({tag, "_rst_data"}, 32'(rsp_data), 32'd0);
      check({tag, "_rst_id"}, 32'(rsp_id), 32'd0);
      check({tag, "_rst_busy"}, 32'(busy), 32'd0);
    end
    last = w;
    @(posedge clk); #1;
    if (drop) req[w] = 1'b0;
    rsp_ready = (delay == 0);
    @(negedge clk);
    check({tag, "_exec_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_exec_busy"}, 32'(busy), 32'd1);
    check({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_alu_a"}, 32'(alu_a), 32'(ea));
    check({tag, "_alu_b"}, 32'(alu_b), 32'(eb));
    check({tag, "_alu_sel"}, 32'(alu_select), 32'(es));
    check({tag, "_alu_mode"}, 32'(alu_mode), 32'(em));
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_data"}, 32'(rsp_data), 32'(ed));
    check({tag, "_id"}, 32'(rsp_id), 32'(w));
    check({tag, "_resp_busy"}, 32'(busy), 32'd1);
    check({tag, "_resp_gnt"}, 32'(gnt), 32'd0);
    for (int k = 1; k <= delay; k++) begin
      @(posedge clk); #1;
      if (k == delay) rsp_ready = 1'b1;
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_data"}, 32'(rsp_data), 32'(ed));
      check({tag, "_hold_id"}, 32'(rsp_id), 32'(w));
      check({tag, "_hold_gnt"}, 32'(gnt), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    last        = N - 1;
    rst         = 1'b1;
    req         = '0;
    req_a       = '0;
    req_b       = '0;
    req_select  = '0;
    req_mode    = '0;
    rsp_ready   = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_gnt", 32'(gnt), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Requester 0: 5 + 3
    set_op(0, 16'd5, 16'd3, 4'b1001, 1'b0);
    txn("t1_add", 4'b0001, 1'b1, 0, 1'b0);
    @(negedge clk);
    check("t1_keep_alu_a", 32'(alu_a), 32'd5);
    check("t1_done_valid", 32'(rsp_valid), 32'd0);
    check("t1_done_busy", 32'(busy), 32'd0);
    check("t1_done_gnt", 32'(gnt), 32'd0);
    @(posedge clk); #1;

    // Requester 2: XOR
    set_op(2, 16'h00F0, 16'h0FF0, 4'b0110, 1'b1);
    txn("t2_xor", 4'b0100, 1'b1, 0, 1'b0);

    // All requesting continuously: rotation, one grant every 3 cycles
    for (int i = 0; i < N; i++) set_op(i, 16'(i * 16'h111), 16'(i + 7), 4'b1001, 1'b0);
    for (int n = 0; n < 5; n++) txn("rot", 4'b1111, 1'b0, 0, 1'b0);

    // Single requester repeated, then back-pressure with another pending
    txn("single", 4'b0010, 1'b1, 0, 1'b0);
    txn("stall", 4'b0110, 1'b1, 5, 1'b0);
    txn("pend", 4'b0010, 1'b1, 0, 1'b0);

    // Reset during RESP with requester 3 waiting
    req       = 4'b0001;
    rsp_ready = 1'b0;
    set_op(3, 16'h1234, 16'h0101, 4'b1110, 1'b1);
    @(negedge clk);
    check("rr_pre_gnt", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    req = 4'b1000;
    @(negedge clk);
    check("rr_exec_gnt", 32'(gnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rr_rst_gnt", 32'(gnt), 32'd0);
    check("rr_resp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    rst  = 1'b0;
    last = N - 1;
`ifdef ALU_ARB_OP_COUNT_EN
    check("cnt_rst", 32'(op_count), 32'd0);
`endif
    txn("rst_first", 4'b1000, 1'b1, 0, 1'b1);

`ifdef ALU_ARB_OP_COUNT_EN
    // Counter wrap
    req = '0;
    force dut.op_count_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.op_count_q;
    txn("cnt1", 4'b0001, 1'b1, 0, 1'b0);
    check("cnt_ffff", 32'(op_count), 32'h0000FFFF);
    txn("cnt2", 4'b0010, 1'b1, 1, 1'b0);
    check("cnt_0000", 32'(op_count), 32'h00000000);
    txn("cnt3", 4'b0100, 1'b1, 0, 1'b0);
    check("cnt_0001", 32'(op_count), 32'h00000001);
`endif

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++)
        set_op(i, 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        req = '0;
        @(negedge clk);
        check("rnd_idle_gnt", 32'(gnt), 32'd0);
        check("rnd_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
      end
      txn("rnd", 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
